// File: rtl/dff_logic_deser.sv
// rtl/dff_logic_deser.sv - serial-to-parallel frame deserializer with sync hunt and lock tracking
module dff_logic_deser #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC      = 8'hA5,
    parameter int               WORDS     = 4,
    parameter int               LOCK_MISS = 2
) (
    input  logic             c,
    input  logic             rst,
    input  logic             d,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int WC_W = ($clog2(WORDS + 1) > 0) ? $clog2(WORDS + 1) : 1;
    localparam int MC_W = ($clog2(LOCK_MISS + 1) > 0) ? $clog2(LOCK_MISS + 1) : 1;

    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WIDTH - 1);
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(WORDS);
    localparam logic [MC_W-1:0] MISS_LAST = MC_W'(LOCK_MISS);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        DATA    = 2'd1,
        SYNCCHK = 2'd2
    } state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_sr;
    logic [BC_W-1:0] r_bitcnt;
    logic [BC_W-1:0] r_fill;
    logic [WC_W-1:0] r_wordcnt;
    logic [MC_W-1:0] r_misscnt;

    logic [WIDTH-1:0] w_nsr;
    logic [WC_W-1:0]  w_word_next;
    logic [MC_W-1:0]  w_miss_next;
    logic             w_sync_hit;
    logic             w_hunt_match;

    assign w_nsr        = {r_sr[WIDTH-2:0], d};
    assign w_word_next  = r_wordcnt + WC_W'(1);
    assign w_miss_next  = r_misscnt + MC_W'(1);
    assign w_sync_hit   = (w_nsr == SYNC);
    // Hunting only matches once WIDTH fresh bits have arrived, so stale bits never alias a sync.
    assign w_hunt_match = w_sync_hit && (r_fill == BIT_LAST);

    always_ff @(posedge c) begin
        if (rst) begin
            r_state   <= HUNT;
            r_sr      <= '0;
            r_bitcnt  <= '0;
            r_fill    <= '0;
            r_wordcnt <= '0;
            r_misscnt <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            r_sr     <= w_nsr;
            q_valid  <= 1'b0;
            sync_err <= 1'b0;
            case (r_state)
                HUNT: begin
                    r_bitcnt  <= '0;
                    r_wordcnt <= '0;
                    r_misscnt <= '0;
                    if (r_fill != BIT_LAST) begin
                        r_fill <= r_fill + BC_W'(1);
                    end
                    if (w_hunt_match) begin
                        r_state <= DATA;
                        locked  <= 1'b1;
                    end
                end
                DATA: begin
                    if (r_bitcnt == BIT_LAST) begin
                        q        <= w_nsr;
                        q_valid  <= 1'b1;
                        r_bitcnt <= '0;
                        if (w_word_next == WORD_LAST) begin
                            r_wordcnt <= '0;
                            r_state   <= SYNCCHK;
                        end else begin
                            r_wordcnt <= w_word_next;
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt + BC_W'(1);
                    end
                end
                SYNCCHK: begin
                    if (r_bitcnt == BIT_LAST) begin
                        r_bitcnt <= '0;
                        if (w_sync_hit) begin
                            r_misscnt <= '0;
                            r_state   <= DATA;
                        end else begin
                            sync_err <= 1'b1;
                            if (w_miss_next == MISS_LAST) begin
                                r_misscnt <= '0;
                                r_fill    <= '0;
                                locked    <= 1'b0;
                                r_state   <= HUNT;
                            end else begin
                                r_misscnt <= w_miss_next;
                                r_state   <= DATA;
                            end
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt + BC_W'(1);
                    end
                end
                default: begin
                    r_state <= HUNT;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_logic_deser.sv
// tb/tb_dff_logic_deser.sv - scoreboard bench for the frame deserializer
module tb_dff_logic_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d   = 1'b1;
    logic [7:0] q;
    logic       q_valid;
    logic       locked;
    logic       sync_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_valid = 0;
    int n_serr  = 0;
    int last_valid_cyc = 0;
    int gap     = 0;
    logic serr_locked = 1'b0;
    logic [7:0] sb[$];

    dff_logic_deser dut (
        .c        (clk),
        .rst      (rst),
        .d        (d),
        .q        (q),
        .q_valid  (q_valid),
        .locked   (locked),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        logic [7:0] exp_w;
        @(negedge clk);
        d = b;
        @(posedge clk);
        #1;
        cyc++;
        if (q_valid === 1'b1) begin
            n_valid++;
            gap = cyc - last_valid_cyc;
            last_valid_cyc = cyc;
            check("valid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                check("q_word", 32'(q), 32'(exp_w));
            end
        end
        if (sync_err === 1'b1) begin
            n_serr++;
            serr_locked = locked;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_word(input logic [7:0] b, input int exp_gap);
        int v0;
        v0 = n_valid;
        sb.push_back(b);
        send_byte(b);
        check("word_strobe", 32'(n_valid), 32'(v0 + 1));
        if (exp_gap != 0) check("strobe_gap", 32'(gap), 32'(exp_gap));
    endtask

    task automatic send_frame(input logic [7:0] w0, w1, w2, w3, input int first_gap);
        send_word(w0, first_gap);
        send_word(w1, 8);
        send_word(w2, 8);
        send_word(w3, 8);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        d   = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("rst_q", 32'(q), 32'h0);
            check("rst_q_valid", 32'(q_valid), 32'h0);
            check("rst_locked", 32'(locked), 32'h0);
            check("rst_sync_err", 32'(sync_err), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int s0;
        int v0;
        logic [7:0] sync_w;
        sync_w = 8'hA5;

        // Reset
        do_reset(3);

        // Lock and deliver
        for (int i = 7; i >= 0; i--) begin
            send_bit(sync_w[i]);
            if (i == 1) check("locked_before_last_sync_bit", 32'(locked), 32'h0);
        end
        check("locked_on_sync", 32'(locked), 32'h1);
        send_frame(8'h3C, 8'hC3, 8'hFF, 8'h00, 0);
        send_byte(8'hA5);
        check("no_sync_err_clean", 32'(n_serr), 32'h0);
        check("locked_after_frame", 32'(locked), 32'h1);
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 16);
        send_byte(8'hA5);

        // Bit slip
        do_reset(1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("slip_unlocked", 32'(locked), 32'h0);
        send_byte(8'hA5);
        check("slip_locked", 32'(locked), 32'h1);
        send_frame(8'h11, 8'h5A, 8'hA5, 8'h81, 0);
        send_byte(8'hA5);

        // Single miss, recovery, second single miss
        send_frame(8'h55, 8'h66, 8'h77, 8'h88, 16);
        s0 = n_serr;
        send_byte(8'h5A);
        check("miss1_sync_err", 32'(n_serr), 32'(s0 + 1));
        check("miss1_locked_at_err", 32'(serr_locked), 32'h1);
        check("miss1_locked", 32'(locked), 32'h1);
        send_frame(8'h99, 8'hAA, 8'hBB, 8'hCC, 16);
        send_byte(8'hA5);
        send_frame(8'h12, 8'h34, 8'h56, 8'h78, 16);
        s0 = n_serr;
        send_byte(8'h5A);
        check("miss2_sync_err", 32'(n_serr), 32'(s0 + 1));
        check("miss2_locked", 32'(locked), 32'h1);
        send_frame(8'h9A, 8'hBC, 8'hDE, 8'hF0, 16);
        send_byte(8'hA5);

        // Loss of lock after two consecutive bad slots
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 16);
        s0 = n_serr;
        send_byte(8'h5A);
        check("loss_first_err_locked", 32'(serr_locked), 32'h1);
        send_frame(8'h05, 8'h06, 8'h07, 8'h08, 16);
        send_byte(8'h5A);
        check("loss_err_count", 32'(n_serr), 32'(s0 + 2));
        check("loss_locked_fell_with_err", 32'(serr_locked), 32'h0);
        check("loss_locked", 32'(locked), 32'h0);
        v0 = n_valid;
        send_byte(8'h3C);
        send_byte(8'h00);
        check("loss_no_valid", 32'(n_valid), 32'(v0));
        check("loss_still_unlocked", 32'(locked), 32'h0);
        check("loss_q_holds", 32'(q), 32'h08);
        send_byte(8'hA5);
        check("relock", 32'(locked), 32'h1);
        send_frame(8'hE1, 8'hE2, 8'hE3, 8'hE4, 0);
        send_byte(8'hA5);

        // Reset mid-word
        v0 = n_valid;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        do_reset(1);
        check("midrst_no_valid", 32'(n_valid), 32'(v0));
        for (int i = 7; i >= 0; i--) send_bit(sync_w[i]);
        check("midrst_relock", 32'(locked), 32'h1);
        send_frame(8'h3C, 8'hC3, 8'h7E, 8'hA5, 0);
        send_byte(8'hA5);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        check("final_locked", 32'(locked), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
